ex_mem_flag_stage: RTL and testbench
====================================

# ex_mem_flag_stage

Pipeline stage directly downstream of the saturating 16-bit ALU adder. Registers the EX-stage ALU result into the EX/MEM pipeline register and maintains the architectural flag register (Z, V, N) with per-opcode selective update. It also resolves conditional branches in EX against the registered flags. Sits between the ALU and the memory/writeback stage; the hazard unit drives its stall and flush.

## Interface
Parameters:
- DATA_W, 16, datapath width. Must match the ALU width.
- REG_W, 4, destination register index width.

Ports:
- clk  in  1  single system clock. All state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- alu_result  in  DATA_W  saturated ALU result for the instruction in EX.
- alu_ovfl  in  1  ALU overflow (saturation occurred).
- alu_sign  in  1  ALU sign flag (alu_result[DATA_W-1]).
- ex_valid  in  1  EX holds a real instruction.
- ex_opcode  in  4  opcode of the EX instruction.
- ex_rd  in  REG_W  destination register.
- ex_wr_en  in  1  EX instruction writes the register file.
- br_en  in  1  EX instruction is a conditional branch.
- br_cond  in  3  branch condition code.
- stall  in  1  hold EX/MEM and flags this cycle.
- flush  in  1  squash the EX instruction.
- mem_result  out  DATA_W  registered result.
- mem_rd  out  REG_W  registered destination.
- mem_wr_en  out  1  registered write enable; 0 whenever mem_valid=0.
- mem_valid  out  1  EX/MEM holds a real instruction.
- flag_z, flag_v, flag_n  out  1 each  architectural flag register.
- br_taken  out  1  combinational branch decision for the EX instruction.

## Operation
- Opcodes: ADD=4'h0, SUB=4'h1, XOR=4'h2, RED=4'h3, SLL=4'h4, SRA=4'h5, ROR=4'h6, PADDSB=4'h7. Values 8–F are non-ALU.
- Define `advance = ex_valid & ~stall & ~flush`.
- Flag update applies only when `advance` is 1.
  - ADD/SUB write all three flags:
    - Z = (alu_result == 0)
    - V = alu_ovfl
    - N = alu_sign
  - XOR/SLL/SRA/ROR write Z only; V and N hold.
  - RED, PADDSB and non-ALU opcodes hold all flags.
- Z is computed in this block from alu_result. The ALU zero flag is not used.
- EX/MEM register behaviour:
  - flush=1: mem_valid←0 and mem_wr_en←0. mem_result and mem_rd are don't-care.
  - else stall=1: all EX/MEM fields hold.
  - else: mem_valid←ex_valid, mem_result←alu_result, mem_rd←ex_rd, mem_wr_en←ex_wr_en & ex_valid.
- flush overrides stall when both are asserted.
- Branch evaluation uses the current registered flags:
  - 000 NEQ: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 & N=0
  - 011 LT: N=1
  - 100 GTE: Z=1 | N=0
  - 101 LTE: Z=1 | N=1
  - 110 OVFL: V=1
  - 111 UNCOND: always taken
- br_taken = ex_valid & br_en & ~flush & ~rst & cond. It is independent of stall; the hazard unit qualifies it.
- A branch never updates flags, whatever its opcode.

## Timing
- Reset, sampled at a rising edge with rst=1: mem_result=0, mem_rd=0, mem_wr_en=0, mem_valid=0, flag_z=0, flag_v=0, flag_n=0.
- br_taken is 0 in every cycle with rst=1.
- rst overrides stall and flush. An instruction in EX during reset is lost; no flag write, no mem_valid.
- Latency: 1 cycle from EX inputs to mem_* and flag_* outputs.
- Back-to-back: a flag-setting instruction in cycle t makes its flags visible to a branch in EX at t+1. No forwarding path from alu_* to branch evaluation.
- Stall held N cycles: outputs and flags hold for N edges. The instruction advances on the first edge with stall=0.
- Saturated results:
  - +32767 from overflow: V=1, N=0, Z=0.
  - −32768: V=1, N=1.

## Structure
- Shared package `alu_pkg` holds:
  - opcode localparams
  - branch condition localparams
  - a packed flags struct {z, v, n}
  - `DATA_W`
- Sub-module `branch_cond_eval`: purely combinational. Inputs: flags and br_cond. Output: cond.
- Pipeline register and flag register live in the top level, `ex_mem_flag_stage`.

## Test plan
- Reset then idle: hold rst=1 for 2 cycles with ex_valid=1, ADD, result 5. Afterwards all outputs are 0 and br_taken=0.
- ADD saturation: ADD with alu_result=16'h7FFF, ovfl=1, sign=0. Next cycle: flags Z=0, V=1, N=0; mem_result=16'h7FFF; mem_valid=1. Then a branch with cc=110 in the following EX gives br_taken=1.
- Selective update: SUB giving result 16'h8000 (ovfl=1, sign=1), then XOR giving result 0. After the XOR: Z=1, V=1, N=1. A following RED with result 3 leaves all flags unchanged.
- Stall/flush: ADD result 0 with stall=1 for 3 cycles. Flags and mem_* hold for those cycles, and Z=1 appears one edge after stall drops. An ADD with stall=1 and flush=1 together gives mem_valid=0 with no flag change.
- Branch conditions: sweep all 8 codes against each flag state (Z,N) ∈ {(0,0),(1,0),(0,1)} with V=0 and V=1. br_taken must match the condition equations, and must be 0 when ex_valid=0 or br_en=0.
- Reset mid-stall: with stall=1 and mem_valid=1, assert rst. The next edge gives mem_valid=0 and flags=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the saturating ALU and its downstream EX/MEM flag stage:
// opcodes, branch condition codes, the architectural flag struct and datapath width.
package alu_pkg;

  localparam int DATA_W = 16;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_RED    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;

  localparam logic [2:0] BR_NEQ    = 3'b000;
  localparam logic [2:0] BR_EQ     = 3'b001;
  localparam logic [2:0] BR_GT     = 3'b010;
  localparam logic [2:0] BR_LT     = 3'b011;
  localparam logic [2:0] BR_GTE    = 3'b100;
  localparam logic [2:0] BR_LTE    = 3'b101;
  localparam logic [2:0] BR_OVFL   = 3'b110;
  localparam logic [2:0] BR_UNCOND = 3'b111;

  typedef struct packed {
    logic z;
    logic v;
    logic n;
  } flags_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator: maps a 3-bit condition code and the
// architectural flags onto a single taken/not-taken condition bit.
module branch_cond_eval
  import alu_pkg::*;
(
  input  flags_t     flags,
  input  logic [2:0] br_cond,
  output logic       cond
);

  always_comb begin
    cond = 1'b0;
    case (br_cond)
      BR_NEQ:    cond = ~flags.z;
      BR_EQ:     cond = flags.z;
      BR_GT:     cond = ~flags.z & ~flags.n;
      BR_LT:     cond = flags.n;
      BR_GTE:    cond = flags.z | ~flags.n;
      BR_LTE:    cond = flags.z | flags.n;
      BR_OVFL:   cond = flags.v;
      BR_UNCOND: cond = 1'b1;
      default:   cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_mem_flag_stage.sv
// EX/MEM pipeline register plus the Z/V/N flag register with per-opcode selective
// update, and EX-stage branch resolution against the registered flags.
module ex_mem_flag_stage #(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_ovfl,
  input  logic              alu_sign,
  input  logic              ex_valid,
  input  logic [3:0]        ex_opcode,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_wr_en,
  input  logic              br_en,
  input  logic [2:0]        br_cond,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] mem_result,
  output logic [REG_W-1:0]  mem_rd,
  output logic              mem_wr_en,
  output logic              mem_valid,
  output logic              flag_z,
  output logic              flag_v,
  output logic              flag_n,
  output logic              br_taken
);

  import alu_pkg::*;

  // Handshake: an EX instruction moves into EX/MEM on a rising edge when
  // ex_valid=1, stall=0 and flush=0; stall freezes EX/MEM and flags, flush
  // (which wins over stall) drops the instruction, and rst wins over both.
  logic [DATA_W-1:0] mem_result_q, mem_result_d;
  logic [REG_W-1:0]  mem_rd_q, mem_rd_d;
  logic              mem_wr_en_q, mem_wr_en_d;
  logic              mem_valid_q, mem_valid_d;
  flags_t            flags_q, flags_d;
  logic              advance;
  logic              cond;

  assign advance = ex_valid & ~stall & ~flush;

  always_comb begin
    mem_result_d = mem_result_q;
    mem_rd_d     = mem_rd_q;
    mem_wr_en_d  = mem_wr_en_q;
    mem_valid_d  = mem_valid_q;
    if (flush) begin
      mem_valid_d = 1'b0;
      mem_wr_en_d = 1'b0;
    end else if (!stall) begin
      mem_valid_d  = ex_valid;
      mem_result_d = alu_result;
      mem_rd_d     = ex_rd;
      mem_wr_en_d  = ex_wr_en & ex_valid;
    end
  end

  // Zero is derived here from the saturated result, not taken from the ALU.
  always_comb begin
    flags_d = flags_q;
    if (advance && !br_en) begin
      case (ex_opcode)
        OP_ADD, OP_SUB: begin
          flags_d.z = (alu_result == '0);
          flags_d.v = alu_ovfl;
          flags_d.n = alu_sign;
        end
        OP_XOR, OP_SLL, OP_SRA, OP_ROR: flags_d.z = (alu_result == '0);
        default: flags_d = flags_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_result_q <= '0;
      mem_rd_q     <= '0;
      mem_wr_en_q  <= 1'b0;
      mem_valid_q  <= 1'b0;
      flags_q      <= '0;
    end else begin
      mem_result_q <= mem_result_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_en_q  <= mem_wr_en_d;
      mem_valid_q  <= mem_valid_d;
      flags_q      <= flags_d;
    end
  end

  branch_cond_eval u_branch_cond_eval (
    .flags   (flags_q),
    .br_cond (br_cond),
    .cond    (cond)
  );

  // No forwarding: the branch sees only flags already committed to flags_q.
  assign br_taken = ex_valid & br_en & ~flush & ~rst & cond;

  assign mem_result = mem_result_q;
  assign mem_rd     = mem_rd_q;
  assign mem_wr_en  = mem_wr_en_q;
  assign mem_valid  = mem_valid_q;
  assign flag_z     = flags_q.z;
  assign flag_v     = flags_q.v;
  assign flag_n     = flags_q.n;

endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// Directed bench for ex_mem_flag_stage: reset, flag selective update, stall/flush,
// branch condition sweep and reset during stall, with hand-computed expectations.
module tb_ex_mem_flag_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] alu_result;
  logic        alu_ovfl;
  logic        alu_sign;
  logic        ex_valid;
  logic [3:0]  ex_opcode;
  logic [3:0]  ex_rd;
  logic        ex_wr_en;
  logic        br_en;
  logic [2:0]  br_cond;
  logic        stall;
  logic        flush;
  logic [15:0] mem_result;
  logic [3:0]  mem_rd;
  logic        mem_wr_en;
  logic        mem_valid;
  logic        flag_z;
  logic        flag_v;
  logic        flag_n;
  logic        br_taken;

  int n_cmp  = 0;
  int n_fail = 0;

  ex_mem_flag_stage #(.DATA_W(16), .REG_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_result (alu_result),
    .alu_ovfl   (alu_ovfl),
    .alu_sign   (alu_sign),
    .ex_valid   (ex_valid),
    .ex_opcode  (ex_opcode),
    .ex_rd      (ex_rd),
    .ex_wr_en   (ex_wr_en),
    .br_en      (br_en),
    .br_cond    (br_cond),
    .stall      (stall),
    .flush      (flush),
    .mem_result (mem_result),
    .mem_rd     (mem_rd),
    .mem_wr_en  (mem_wr_en),
    .mem_valid  (mem_valid),
    .flag_z     (flag_z),
    .flag_v     (flag_v),
    .flag_n     (flag_n),
    .br_taken   (br_taken)
  );

  // Clock/reset block
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] res,
                       input logic ov, input logic [3:0] rd, input logic we);
    ex_valid   = v;
    ex_opcode  = op;
    alu_result = res;
    alu_ovfl   = ov;
    alu_sign   = res[15];
    ex_rd      = rd;
    ex_wr_en   = we;
    br_en      = 1'b0;
    br_cond    = 3'b000;
    stall      = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic [2:0] exp_zvn);
    chk(tag, {29'd0, flag_z, flag_v, flag_n}, {29'd0, exp_zvn});
  endtask

  task automatic chk_mem(input string tag, input logic [15:0] res, input logic vld,
                         input logic we);
    chk({tag, "_result"}, {16'd0, mem_result}, {16'd0, res});
    chk({tag, "_valid"}, {31'd0, mem_valid}, {31'd0, vld});
    chk({tag, "_wr_en"}, {31'd0, mem_wr_en}, {31'd0, we});
  endtask

  // Per flag state: ADD result/ovfl that sets it, expected {z,v,n}, and taken mask by cc
  logic [15:0] st_res  [6] = '{16'h0001, 16'h0000, 16'hFFFF, 16'h7FFF, 16'h0000, 16'h8000};
  logic        st_ov   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [2:0]  st_zvn  [6] = '{3'b000, 3'b100, 3'b001, 3'b010, 3'b110, 3'b011};
  logic [7:0]  st_mask [6] = '{8'h95, 8'hB2, 8'hA9, 8'hD5, 8'hF2, 8'hE9};

  initial begin
    // Reset with a live ADD in EX and a live unconditional branch request
    drive(1'b1, 4'h0, 16'h0005, 1'b0, 4'h3, 1'b1);
    rst     = 1'b1;
    br_en   = 1'b1;
    br_cond = 3'b111;
    #1;
    chk("rst_br_taken", {31'd0, br_taken}, 32'd0);
    tick();
    tick();
    chk_mem("rst", 16'h0000, 1'b0, 1'b0);
    chk("rst_rd", {28'd0, mem_rd}, 32'd0);
    chk_flags("rst_flags", 3'b000);
    chk("rst_br_taken2", {31'd0, br_taken}, 32'd0);
    rst = 1'b0;
    drive(1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 1'b0);
    tick();
    chk_mem("idle", 16'h0000, 1'b0, 1'b0);
    chk_flags("idle_flags", 3'b000);
    chk("idle_br_taken", {31'd0, br_taken}, 32'd0);

    // ADD saturating to +32767
    drive(1'b1, 4'h0, 16'h7FFF, 1'b1, 4'h5, 1'b1);
    tick();
    chk_flags("add_sat_flags", 3'b010);
    chk_mem("add_sat", 16'h7FFF, 1'b1, 1'b1);
    chk("add_sat_rd", {28'd0, mem_rd}, 32'd5);
    // Branch on OVFL; its ADD opcode with result 0 must not touch flags
    drive(1'b1, 4'h0, 16'h0000, 1'b0, 4'h2, 1'b0);
    br_en   = 1'b1;
    br_cond = 3'b110;
    #1;
    chk("ovfl_br_taken", {31'd0, br_taken}, 32'd1);
    tick();
    chk_flags("branch_no_flag_write", 3'b010);
    chk_mem("branch_mem", 16'h0000, 1'b1, 1'b0);

    // Selective update: SUB, XOR, RED, SLL, non-ALU
    drive(1'b1, 4'h1, 16'h8000, 1'b1, 4'h1, 1'b1);
    tick();
    chk_flags("sub_sat_flags", 3'b011);
    drive(1'b1, 4'h2, 16'h0000, 1'b0, 4'h1, 1'b1);
    tick();
    chk_flags("xor_zero_flags", 3'b111);
    drive(1'b1, 4'h3, 16'h0003, 1'b0, 4'h1, 1'b1);
    tick();
    chk_flags("red_hold_flags", 3'b111);
    chk("red_result", {16'd0, mem_result}, 32'h0003);
    drive(1'b1, 4'h4, 16'h0005, 1'b1, 4'h1, 1'b1);
    tick();
    chk_flags("sll_z_only", 3'b011);
    drive(1'b1, 4'h8, 16'h0044, 1'b0, 4'h7, 1'b1);
    tick();
    chk_flags("nonalu_hold", 3'b011);
    chk_mem("nonalu", 16'h0044, 1'b1, 1'b1);

    // Stall for 3 cycles with ADD result 0 waiting in EX
    drive(1'b1, 4'h0, 16'h0000, 1'b0, 4'h9, 1'b1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_flags("stall_flags_hold", 3'b011);
      chk_mem("stall_hold", 16'h0044, 1'b1, 1'b1);
      chk("stall_rd_hold", {28'd0, mem_rd}, 32'd7);
    end
    stall = 1'b0;
    tick();
    chk_flags("post_stall_flags", 3'b100);
    chk_mem("post_stall", 16'h0000, 1'b1, 1'b1);
    chk("post_stall_rd", {28'd0, mem_rd}, 32'd9);

    // Stall and flush together: flush wins, no flag change
    drive(1'b1, 4'h0, 16'h1234, 1'b1, 4'h4, 1'b1);
    stall   = 1'b1;
    flush   = 1'b1;
    br_en   = 1'b1;
    br_cond = 3'b111;
    #1;
    chk("flush_br_taken", {31'd0, br_taken}, 32'd0);
    tick();
    chk("flush_valid", {31'd0, mem_valid}, 32'd0);
    chk("flush_wr_en", {31'd0, mem_wr_en}, 32'd0);
    chk_flags("flush_flags", 3'b100);
    flush = 1'b0;
    #1;
    chk("stall_br_taken", {31'd0, br_taken}, 32'd1);

    // Branch condition sweep over six flag states
    for (int s = 0; s < 6; s++) begin
      drive(1'b1, 4'h0, st_res[s], st_ov[s], 4'h1, 1'b1);
      tick();
      chk_flags("sweep_flags", st_zvn[s]);
      for (int cc = 0; cc < 8; cc++) begin
        drive(1'b1, 4'h0, 16'h0000, 1'b0, 4'h0, 1'b0);
        br_en   = 1'b1;
        br_cond = 3'(cc);
        #1;
        chk($sformatf("sweep_s%0d_cc%0d", s, cc), {31'd0, br_taken}, {31'd0, st_mask[s][cc]});
      end
      ex_valid = 1'b0;
      br_cond  = 3'b111;
      #1;
      chk("sweep_no_valid", {31'd0, br_taken}, 32'd0);
      ex_valid = 1'b1;
      br_en    = 1'b0;
      #1;
      chk("sweep_no_br_en", {31'd0, br_taken}, 32'd0);
    end

    // Reset asserted mid-stall
    drive(1'b1, 4'h0, 16'h8000, 1'b1, 4'h6, 1'b1);
    tick();
    chk("pre_rst_valid", {31'd0, mem_valid}, 32'd1);
    chk_flags("pre_rst_flags", 3'b011);
    drive(1'b1, 4'h0, 16'h0000, 1'b0, 4'h6, 1'b1);
    stall   = 1'b1;
    rst     = 1'b1;
    br_en   = 1'b1;
    br_cond = 3'b111;
    #1;
    chk("rst_stall_br_taken", {31'd0, br_taken}, 32'd0);
    tick();
    chk_mem("rst_stall", 16'h0000, 1'b0, 1'b0);
    chk_flags("rst_stall_flags", 3'b000);
    rst = 1'b0;
    drive(1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 1'b0);
    tick();

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
